// File: rtl/sng_mc_if.sv
// sng_mc_if -- handshake / data bundle for the multi-channel stochastic
// number generator.
//   master : drives start and a, observes status and results (testbench/host)
//   slave  : the generator side (sng_mc)
// Signals:
//   start     conversion request, sampled only while the generator is idle
//   a         packed channel inputs, channel k at a[k*WIDTH +: WIDTH]
//   busy      high while bits are being produced
//   bit_valid high on cycles where bit_out carries a fresh bit
//   bit_out   per-channel current stochastic bit
//   sbs       collected bitstream, channel k bit i at sbs[k*BSL+i]
//   done      one-cycle pulse once the bitstream is complete
//   ones_cnt  per-channel ones count (zero unless the counter is built in)
interface sng_mc_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int BSL   = 255
) ();
  localparam int CW = $clog2(BSL + 1);

  logic                  start;
  logic [N_CH*WIDTH-1:0] a;
  logic                  busy;
  logic                  bit_valid;
  logic [N_CH-1:0]       bit_out;
  logic [N_CH*BSL-1:0]   sbs;
  logic                  done;
  logic [N_CH*CW-1:0]    ones_cnt;

  modport master (output start, a,
                  input  busy, bit_valid, bit_out, sbs, done, ones_cnt);
  modport slave  (input  start, a,
                  output busy, bit_valid, bit_out, sbs, done, ones_cnt);
endinterface

// File: rtl/sng_mc.sv
// sng_mc -- multi-channel stochastic number generator.
// Converts N_CH binary values into BSL-bit unipolar bitstreams by comparing
// each value against a shared random source (LFSR or van der Corput), with
// the source rotated per channel so channels stay decorrelated.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  sng_mc_if.slave (start, a in; busy, bit_valid, bit_out, sbs, done,
//        ones_cnt out)
// Build option: define SNG_MC_ONES_CNT_EN to include the per-channel ones
// counters; otherwise ones_cnt is tied to zero.

// Per-channel comparator: rotates the shared random value by ROT bits and
// compares it with the latched channel value.
module sng_mc_lane #(
  parameter int WIDTH     = 8,
  parameter int ROT       = 0,
  parameter bit GT_STRICT = 1'b0
) (
  input  logic [WIDTH-1:0] a_k,
  input  logic [WIDTH-1:0] rnd,
  output logic             bit_o
);
  logic [WIDTH-1:0] r_k;

  // ROT == 0 degenerates to rnd | rnd, so no special case is needed.
  assign r_k   = (rnd << ROT) | (rnd >> ((WIDTH - ROT) % WIDTH));
  // LFSR never produces 0, so >= lets a=0 give all zeros and a=max all ones;
  // the counter source includes 0, so strict > keeps the mean at a/2^WIDTH.
  assign bit_o = GT_STRICT ? (a_k > r_k) : (a_k >= r_k);
endmodule

module sng_mc #(
  parameter int N_CH      = 4,
  parameter int WIDTH     = 8,
  parameter int BSL       = 255,
  parameter int GEN_TYPE  = 0,
  parameter int LFSR_SEED = 244
) (
  input  logic     clk,
  input  logic     rst,
  sng_mc_if.slave  bus
);
  localparam int CW    = $clog2(BSL + 1);
  localparam int CNT_W = $clog2(BSL);
  localparam int IDX_W = (CNT_W < 1) ? 1 : CNT_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx;
  logic [WIDTH-1:0]      lfsr, lfsr_nxt, rnd;
  logic [N_CH*WIDTH-1:0] a_q;
  logic [N_CH*BSL-1:0]   sbs_q;
  logic [N_CH-1:0]       bits;
  logic                  run, last, launch;

  assign run    = (state == RUN);
  assign last   = (idx == IDX_W'(BSL - 1));
  assign launch = (state == IDLE) && bus.start;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = run;
    bus.bit_valid = run;
    bus.done      = (state == DONE);
    bus.bit_out   = run ? bits : '0;
  end

  // ---------------- random source ----------------
  generate
    if (WIDTH == 16) begin : g_tap16
      assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end else begin : g_tap8
      assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    if (GEN_TYPE == 1) begin : g_vdc
      logic [WIDTH-1:0] idx_w;
      assign idx_w = WIDTH'(idx);
      always_comb begin
        rnd = '0;
        for (int i = 0; i < WIDTH; i++) rnd[i] = idx_w[WIDTH-1-i];
      end
    end else begin : g_lfsr
      assign rnd = lfsr;
    end
  endgenerate

  // ---------------- channel comparators ----------------
  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_lane
      sng_mc_lane #(
        .WIDTH     (WIDTH),
        .ROT       (k % WIDTH),
        .GT_STRICT (GEN_TYPE == 1)
      ) u_lane (
        .a_k   (a_q[k*WIDTH +: WIDTH]),
        .rnd   (rnd),
        .bit_o (bits[k])
      );
    end
  endgenerate

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx   <= '0;
      lfsr  <= WIDTH'(LFSR_SEED);
      a_q   <= '0;
      sbs_q <= '0;
    end else if (launch) begin
      idx   <= '0;
      lfsr  <= WIDTH'(LFSR_SEED);
      a_q   <= bus.a;
      sbs_q <= '0;
    end else if (run) begin
      idx  <= idx + IDX_W'(1);
      lfsr <= lfsr_nxt;
      for (int k = 0; k < N_CH; k++) sbs_q[k*BSL + int'(idx)] <= bits[k];
    end
  end

  assign bus.sbs = sbs_q;

`ifdef SNG_MC_ONES_CNT_EN
  logic [N_CH*CW-1:0] ones_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones_q <= '0;
    end else if (launch) begin
      ones_q <= '0;
    end else if (run) begin
      for (int k = 0; k < N_CH; k++)
        if (bits[k]) ones_q[k*CW +: CW] <= ones_q[k*CW +: CW] + CW'(1);
    end
  end

  assign bus.ones_cnt = ones_q;
`else
  assign bus.ones_cnt = '0;
`endif

endmodule

// File: tb/tb_sng_mc.sv
module tb_sng_mc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sng_mc_if #(.N_CH(4), .WIDTH(8), .BSL(255)) m0 ();
  sng_mc_if #(.N_CH(4), .WIDTH(8), .BSL(256)) m1 ();

  sng_mc #(.N_CH(4), .WIDTH(8), .BSL(255), .GEN_TYPE(0), .LFSR_SEED(244))
    u_lfsr (.clk(clk), .rst(rst), .bus(m0));
  sng_mc #(.N_CH(4), .WIDTH(8), .BSL(256), .GEN_TYPE(1), .LFSR_SEED(244))
    u_vdc  (.clk(clk), .rst(rst), .bus(m1));

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference bitstream for channel k, straight from the generator definition.
  function automatic logic [255:0] model(input int gt, input int bsl, input logic [31:0] av, input int k);
    logic [7:0] lf, r, rv, rk, ak;
    logic [255:0] s;
    lf = 8'd244;
    s  = '0;
    ak = av[k*8 +: 8];
    for (int i = 0; i < bsl; i++) begin
      rv = 8'(i);
      for (int j = 0; j < 8; j++) r[j] = rv[7-j];
      if (gt == 0) r = lf;
      rk = (r << k) | (r >> (8 - k));
      s[i] = (gt != 0) ? (ak > rk) : (ak >= rk);
      lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
    end
    return s;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel != 0) ? m1.done : m0.done;
  endfunction

  function automatic logic [255:0] get_sbs(input int sel, input int k);
    if (sel != 0) return m1.sbs[k*256 +: 256];
    return 256'(m0.sbs[k*255 +: 255]);
  endfunction

  function automatic logic [255:0] get_ones(input int sel, input int k);
    if (sel != 0) return 256'(m1.ones_cnt[k*9 +: 9]);
    return 256'(m0.ones_cnt[k*8 +: 8]);
  endfunction

  task automatic set_in(input int sel, input logic st, input logic [31:0] av);
    if (sel != 0) begin m1.start = st; m1.a = av; end
    else          begin m0.start = st; m0.a = av; end
  endtask

  // One full conversion: start, optional stray start mid-run, a scrambled
  // after latch, then latency / pulse count / bitstream / counter checks.
  task automatic do_run(input string tag, input int sel, input logic [31:0] av, input bit inject);
    int bsl, n, first, dcnt;
    logic [255:0] exp;
    bsl = (sel != 0) ? 256 : 255;
    set_in(sel, 1'b1, av);
    @(posedge clk); #1;
    set_in(sel, 1'b0, av);
    check({tag, "_busy1"}, (sel != 0) ? m1.busy : m0.busy, 1);
    check({tag, "_bv1"}, (sel != 0) ? m1.bit_valid : m0.bit_valid, 1);
    first = -1; dcnt = 0;
    for (n = 0; n < 400; n++) begin
      if (get_done(sel)) begin
        if (first < 0) first = n + 1;
        dcnt++;
      end
      if (n == 10) set_in(sel, 1'b0, ~av);
      set_in(sel, inject && (n == 50), (n >= 10) ? ~av : av);
      @(posedge clk); #1;
    end
    set_in(sel, 1'b0, av);
    check({tag, "_done_cyc"}, 256'(first), 256'(bsl + 1));
    check({tag, "_done_cnt"}, 256'(dcnt), 1);
    check({tag, "_idle_bv"}, (sel != 0) ? m1.bit_valid : m0.bit_valid, 0);
    for (int k = 0; k < 4; k++) begin
      exp = model(sel, bsl, av, k);
      check($sformatf("%s_sbs%0d", tag, k), get_sbs(sel, k), exp);
`ifdef SNG_MC_ONES_CNT_EN
      check($sformatf("%s_ones%0d", tag, k), get_ones(sel, k), 256'($countones(exp)));
`else
      check($sformatf("%s_ones%0d", tag, k), get_ones(sel, k), 0);
`endif
    end
  endtask

  localparam logic [31:0] A_MIX = {8'd200, 8'd100, 8'd0, 8'd255};

  initial begin
    logic [255:0] full255;
    int dcnt;
    full255 = '0;
    for (int i = 0; i < 255; i++) full255[i] = 1'b1;
    m0.start = 0; m0.a = '0;
    m1.start = 0; m1.a = '0;

    // reset state
    #12;
    check("rst_busy", m0.busy, 0);
    check("rst_done", m0.done, 0);
    check("rst_bv", m0.bit_valid, 0);
    check("rst_bout", 256'(m0.bit_out), 0);
    check("rst_sbs", 256'(|m0.sbs), 0);
    check("rst_ones", 256'(|m1.ones_cnt), 0);
    #1 rst = 1;
    @(posedge clk); #1;

    // LFSR: extremes plus mid values, then an identical back-to-back run
    // with a stray start mid-run.
    do_run("lfsr1", 0, A_MIX, 1'b0);
    check("lfsr_all1", get_sbs(0, 0), full255);
    check("lfsr_all0", get_sbs(0, 1), 0);
    @(posedge clk); #1;
    do_run("lfsr2", 0, A_MIX, 1'b1);

    // van der Corput, a=128 everywhere: exactly half ones
    do_run("vdc", 1, {4{8'd128}}, 1'b0);
    for (int k = 0; k < 4; k++)
      check($sformatf("vdc_pop%0d", k), 256'($countones(get_sbs(1, k))), 128);

    // abort at idx=100
    set_in(0, 1'b1, A_MIX);
    @(posedge clk); #1;
    set_in(0, 1'b0, A_MIX);
    for (int n = 0; n < 100; n++) begin @(posedge clk); #1; end
    #1 rst = 0;
    #1;
    check("abort_busy", m0.busy, 0);
    check("abort_bv", m0.bit_valid, 0);
    check("abort_sbs", 256'(|m0.sbs), 0);
    check("abort_ones", 256'(|m0.ones_cnt), 0);
    dcnt = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (m0.done) dcnt++;
    end
    rst = 1;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (m0.done) dcnt++;
    end
    check("abort_nodone", 256'(dcnt), 0);
    do_run("post_rst", 0, {8'd17, 8'd255, 8'd128, 8'd1}, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sng_mc.md
SNG_MC -- requirements
Module: sng_mc

Interface
REQ-001 Parameter N_CH, default 4: number of independent stochastic channels.
REQ-002 Parameter WIDTH, default 8: binary input and random-number width; legal values 8 and 16.
REQ-003 Parameter BSL, default 255: bitstream length in cycles, 1..2^WIDTH.
REQ-004 Parameter GEN_TYPE, default 0: 0 = LFSR source, 1 = van der Corput (bit-reversed counter) source.
REQ-005 Parameter LFSR_SEED, default 244: non-zero LFSR load value, WIDTH bits.
REQ-006 Derived CW = $clog2(BSL+1); CNT_W = $clog2(BSL).
REQ-007 clk  input  1  single clock; all state updates on the rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  request a conversion; sampled only in IDLE.
REQ-010 a  input  N_CH*WIDTH  channel k binary value in a[k*WIDTH +: WIDTH].
REQ-011 busy  output  1  high in RUN.
REQ-012 bit_valid  output  1  high on cycles where bit_out carries a new bitstream bit.
REQ-013 bit_out  output  N_CH  current stochastic bit per channel.
REQ-014 sbs  output  N_CH*BSL  collected bitstream; channel k bit i at sbs[k*BSL+i].
REQ-015 done  output  1  one-cycle pulse when the bitstream is complete.
REQ-016 ones_cnt  output  N_CH*CW  per-channel count of ones (see Configuration).

Function
REQ-017 FSM states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after bit index BSL-1 is produced; DONE->IDLE unconditionally next cycle.
REQ-018 On IDLE->RUN: a latched into an internal register, index counter cleared to 0, LFSR reloaded with LFSR_SEED, ones_cnt cleared, sbs cleared.
REQ-019 In RUN each cycle: bit_valid=1, bit_out[k] and sbs[k*BSL+idx] produced combinationally from the current random value, then idx and generator advance; registered outputs update at that edge.
REQ-020 Channel k compares against r_k = current random value rotated left by k bits (mod WIDTH) to decorrelate channels.
REQ-021 GEN_TYPE 0: bit = (a_k >= r_k); LFSR is Fibonacci, shift left, feedback into bit 0; taps WIDTH=8: bits 7,5,4,3; WIDTH=16: bits 15,13,12,10; maximal length, never zero.
REQ-022 GEN_TYPE 1: r = bit-reverse of the low WIDTH bits of idx; bit = (a_k > r_k).
REQ-023 Latency: first bit_valid on the cycle after start is sampled; done asserted exactly BSL+1 cycles after start sampled.
REQ-024 start during RUN or DONE ignored; a changes after latch have no effect on the running conversion.
REQ-025 sbs and ones_cnt hold their values from DONE until the next start.
REQ-026 bit_out = 0 and bit_valid = 0 outside RUN.

Reset
REQ-027 rst=0 asynchronously forces IDLE; busy, done, bit_valid, bit_out, sbs, ones_cnt, idx = 0; LFSR = LFSR_SEED.
REQ-028 Reset during RUN aborts the conversion; no done pulse is produced for it.
REQ-029 First start after reset release sampled on any rising edge with rst=1.

Configuration
REQ-030 Macro SNG_MC_ONES_CNT_EN defined: ones_cnt[k] increments by 1 on every RUN cycle with bit_out[k]=1, final value valid when done=1.
REQ-031 SNG_MC_ONES_CNT_EN undefined: no counter logic; ones_cnt tied to all zeros; all other behaviour unchanged.

Verification
REQ-032 GEN_TYPE=1, WIDTH=8, BSL=256, all a_k=128, start -> done at cycle 257, every channel exactly 128 ones in sbs (ones_cnt=128 with macro).
REQ-033 GEN_TYPE=0, WIDTH=8, BSL=255, a_k=255 -> all 255 bits 1 per channel; a_k=0 -> all bits 0.
REQ-034 Two back-to-back runs with identical a (start re-asserted in IDLE after done) -> bit-identical sbs (LFSR reseeded).
REQ-035 start pulsed again mid-RUN -> ignored, done still at cycle BSL+1 after original start, single done pulse.
REQ-036 rst dropped at idx=100 -> busy, bit_valid, sbs, ones_cnt 0 immediately; no done; new start gives full correct run.
REQ-037 Build without SNG_MC_ONES_CNT_EN, repeat REQ-032 -> sbs identical, ones_cnt stays 0.
